// File: rtl/encoder_pkg.sv
// Shared types and helpers for the registered priority/round-robin encoder.
package encoder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Index width for n request lines, never below 1 bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/encoder_prior_rr_if.sv
// Request/grant bundle between a requester/consumer (master) and the encoder (slave).
interface encoder_prior_rr_if
    import encoder_pkg::*;
#(
    parameter int unsigned N = 8
);
    localparam int unsigned W = idx_width(N);

    logic [N-1:0] req;
    logic         rr_en;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;

    modport master (
        output req, rr_en, out_ready,
        input  out_valid, out_idx, out_onehot
    );

    modport slave (
        input  req, rr_en, out_ready,
        output out_valid, out_idx, out_onehot
    );

endinterface

// File: rtl/prior_find_first.sv
// Combinational downward scan for the first set bit, MSB-first or wrapping from start.
module prior_find_first
    import encoder_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    input  logic         wrap_en,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        int unsigned s;
        int unsigned j;
        found = 1'b0;
        idx   = '0;
        // Fixed mode is just a wrap scan that always starts at the top line.
        s = (wrap_en && (32'(start) < N)) ? 32'(start) : N - 1;
        for (int unsigned k = 0; k < N; k++) begin
            j = (s + N - k) % N;
            if (!found && vec[W'(j)]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/encoder_prior_rr.sv
// Registered N-to-log2(N) priority encoder with round-robin option and valid/ready output.
module encoder_prior_rr
    import encoder_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic              clk,
    input  logic              rst,
    encoder_prior_rr_if.slave bus
);

    localparam int unsigned W = idx_width(N);

    state_t       state;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_served;
    logic [W-1:0] scan_start;
    logic         handshake;
    logic         win_found;
    logic [W-1:0] win_idx;
    logic         valid_q;
    logic [W-1:0] idx_q;
    logic [N-1:0] onehot_q;

    assign bus.out_valid  = valid_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = onehot_q;

    // The scan uses the pointer as it will be after this handshake so that
    // back-to-back round-robin grants advance every cycle.
    always_comb begin
        handshake  = (state == ST_HOLD) && bus.out_ready;
        ptr_served = (idx_q == '0) ? W'(N - 1) : idx_q - 1'b1;
        scan_start = ptr;
        if (handshake && bus.rr_en) begin
            scan_start = ptr_served;
        end
    end

    prior_find_first #(
        .N(N)
    ) u_find (
        .vec    (bus.req),
        .start  (scan_start),
        .wrap_en(bus.rr_en),
        .found  (win_found),
        .idx    (win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= W'(N - 1);
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state    <= ST_HOLD;
                        valid_q  <= 1'b1;
                        idx_q    <= win_idx;
                        onehot_q <= N'(1) << win_idx;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        if (bus.rr_en) begin
                            ptr <= ptr_served;
                        end
                        if (win_found) begin
                            idx_q    <= win_idx;
                            onehot_q <= N'(1) << win_idx;
                        end else begin
                            state    <= ST_IDLE;
                            valid_q  <= 1'b0;
                            idx_q    <= '0;
                            onehot_q <= '0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    valid_q  <= 1'b0;
                    idx_q    <= '0;
                    onehot_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_prior_rr.sv
// Scoreboard bench for encoder_prior_rr: directed scenarios plus randomized traffic vs a reference model.
module tb_encoder_prior_rr;

    localparam int unsigned N = 8;

    typedef struct {
        bit    valid;
        int    idx;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    encoder_prior_rr_if #(.N(N)) bus ();

    encoder_prior_rr #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state: what the consumer should see after each edge.
    bit m_valid;
    int m_idx;
    int m_ptr;

    function automatic int pick_winner(input logic [N-1:0] r, input bit rr, input int start);
        int below = -1;
        int top   = -1;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                top = i;
                if (!rr || i <= start) below = i;
            end
        end
        return (below >= 0) ? below : top;
    endfunction

    function automatic logic [N-1:0] onehot_of(input bit v, input int i);
        logic [N-1:0] one;
        one = 1;
        return v ? (one << i) : '0;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = N - 1;
    endtask

    task automatic model_step(input logic [N-1:0] r, input bit rr, input bit rdy);
        if (!m_valid) begin
            if (r != 0) begin
                m_valid = 1;
                m_idx   = pick_winner(r, rr, m_ptr);
            end
        end else if (rdy) begin
            if (rr) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
            if (r != 0) begin
                m_idx = pick_winner(r, rr, m_ptr);
            end else begin
                m_valid = 0;
                m_idx   = 0;
            end
        end
    endtask

    // Called at a falling edge: apply inputs for the next rising edge and queue the expected result.
    task automatic drive_exp(input logic [N-1:0] r, input bit rr, input bit rdy,
                             input bit v, input int i, input string tag);
        exp_t e;
        bus.req = r; bus.rr_en = rr; bus.out_ready = rdy;
        e.valid = v; e.idx = i; e.tag = tag;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drive_rand(input logic [N-1:0] r, input bit rr, input bit rdy);
        exp_t e;
        bus.req = r; bus.rr_en = rr; bus.out_ready = rdy;
        model_step(r, rr, rdy);
        e.valid = m_valid; e.idx = m_idx; e.tag = "random";
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        compared++;
        if (bus.out_valid !== 1'b0 || bus.out_idx !== '0 || bus.out_onehot !== '0) begin
            mismatched++;
            $display("FAIL %s: got valid=%0b idx=%0d onehot=%b, want valid=0 idx=0 onehot=0",
                     tag, bus.out_valid, bus.out_idx, bus.out_onehot);
        end
    endtask

    // Monitor: one queued expectation per rising edge, sampled just after it.
    initial begin
        exp_t e;
        logic [N-1:0] oh;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                oh = onehot_of(e.valid, e.idx);
                compared++;
                if (bus.out_valid !== e.valid || int'(bus.out_idx) != e.idx || bus.out_onehot !== oh) begin
                    mismatched++;
                    $display("FAIL %s @%0t: got valid=%0b idx=%0d onehot=%b, want valid=%0b idx=%0d onehot=%b",
                             e.tag, $time, bus.out_valid, bus.out_idx, bus.out_onehot, e.valid, e.idx, oh);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] r;
        bit rr;
        bus.req = 8'hFF; bus.rr_en = 1'b0; bus.out_ready = 1'b0;

        // Reset holds outputs at zero even with every line requesting.
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        @(negedge clk);
        rst = 1'b0;
        drive_exp(8'hFF, 0, 1, 1, 7, "post_reset_first");

        // Fixed priority.
        drive_exp(8'b0000_0011, 0, 1, 1, 1, "fixed_0011");
        drive_exp(8'h00, 0, 1, 0, 0, "fixed_drain");
        drive_exp(8'h00, 0, 1, 0, 0, "fixed_idle");

        // Backpressure freezes the held winner.
        drive_exp(8'b0000_0011, 0, 0, 1, 1, "bp_load");
        repeat (3) drive_exp(8'h80, 0, 0, 1, 1, "bp_stall");
        drive_exp(8'h80, 0, 1, 1, 7, "bp_release");
        drive_exp(8'h00, 0, 1, 0, 0, "bp_drain");

        // Round-robin under full load.
        for (int k = 0; k < 9; k++) drive_exp(8'hFF, 1, 1, 1, (7 - k + 8) % 8, "rr_full");

        // Sparse round-robin continues from the grant to 7, then fixed mode.
        for (int k = 0; k < 4; k++) drive_exp(8'h81, 1, 1, 1, (k % 2 == 0) ? 0 : 7, "rr_sparse");
        repeat (3) drive_exp(8'h81, 0, 1, 1, 7, "fixed_sparse");
        drive_exp(8'h00, 0, 1, 0, 0, "sparse_drain");

        // Reset while holding the grant to 5.
        drive_exp(8'hFF, 1, 1, 1, 7, "rr_pre_reset");
        drive_exp(8'hFF, 1, 1, 1, 6, "rr_pre_reset");
        drive_exp(8'hFF, 1, 1, 1, 5, "rr_pre_reset");
        drive_exp(8'hFF, 1, 0, 1, 5, "rr_hold5");
        bus.req = '0; bus.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset_mid_hold");
        @(negedge clk);
        rst = 1'b0;
        drive_exp(8'hFF, 1, 1, 1, 7, "rr_after_reset");
        drive_exp(8'h00, 1, 1, 0, 0, "rr_after_reset_drain");

        // Randomized traffic against the reference model from a fresh reset.
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rr = 1'b0;
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = 8'(1 << $urandom_range(0, N - 1));
                default: r = 8'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) rr = ~rr;
            drive_rand(r, rr, $urandom_range(0, 3) != 0);
        end

        for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations never observed, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/encoder_prior_rr.md
Name: encoder_prior_rr

Overview:
Parametrised, registered N-to-log2(N) priority encoder with an optional round-robin mode and a valid/ready output handshake. It samples a request vector, selects one winner, and holds that winner stable until the consumer accepts it. It is the clocked, generalised successor of the 4-to-2 priority encoder. Typical uses are interrupt-source selection and shared-resource arbitration.

Parameters:
N, 8, number of request lines; legal range N >= 2.
W, $clog2(N), index width; derived, not overridden.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
req  input  N  request vector; bit i set means line i requests.
rr_en  input  1  0 = fixed priority (MSB highest); 1 = round-robin.
out_ready  input  1  consumer accepts the current winner.
out_valid  output  1  out_idx/out_onehot hold a valid winner.
out_idx  output  W  binary index of the winner.
out_onehot  output  N  one-hot form of the winner.

Behaviour:
- Single clock domain on clk. Reset is asynchronous, active-high, on rst.
- Reset values: out_valid=0, out_idx=0, out_onehot=0, state=IDLE, ptr=N-1.
- FSM states:
  - IDLE: no winner held.
  - HOLD: winner registered, out_valid=1.
- Transitions:
  - IDLE, req==0: stay in IDLE.
  - IDLE, req!=0: register the winner and go to HOLD. Latency is 1 cycle (req sampled at edge t, out_valid=1 after edge t).
  - HOLD, out_ready==0: all outputs frozen. Changes on req and rr_en are ignored.
  - HOLD, out_ready==1 (handshake) and req!=0: load the next winner from the current req and stay in HOLD. This gives back-to-back grants at 1 per cycle.
  - HOLD, out_ready==1 and req==0: go to IDLE. out_valid=0 and outputs cleared to 0 on the same edge.
- Winner selection (combinational, on the current req):
  - Fixed mode: the highest set index wins; for example req=0011 gives 1.
  - RR mode: scan downward from ptr, wrapping from 0 to N-1. The first set bit wins.
- Pointer update:
  - ptr updates only on a handshake while rr_en=1: ptr <= (out_idx==0) ? N-1 : out_idx-1. The just-served line therefore becomes lowest priority.
  - In fixed mode ptr is not modified.
  - Switching rr_en takes effect at the next winner load.
- Output invariants:
  - out_onehot == (1 << out_idx) whenever out_valid=1.
  - Both outputs are 0 whenever out_valid=0.
- Index arithmetic is modulo N. N need not be a power of 2; indices >= N never appear.
- rst asserted mid-operation (including HOLD) clears out_valid and all outputs immediately, without waiting for clk. ptr returns to N-1, so the first RR grant after reset equals the fixed-priority grant.
- Simultaneous events: a handshake and a new req in the same cycle resolve as defined above. There is no bubble cycle.

Decomposition:
- Shared package encoder_pkg holds:
  - state typedef/localparams ST_IDLE=1'b0, ST_HOLD=1'b1;
  - the index-width helper function.
- Natural sub-module: prior_find_first, parameter N.
  - Purely combinational.
  - Inputs: vec[N-1:0], start[W-1:0], wrap_en.
  - Outputs: found, idx[W-1:0].
  - With wrap_en=0 it is the fixed MSB-first scan; with wrap_en=1 and start=ptr it is the RR scan.
- Top level holds the FSM, ptr and output registers only.

Test Plan:
- Reset: rst=1 with req=8'hFF -> out_valid=0, out_idx=0, out_onehot=0. After rst=0, valid rises one clk later with out_idx=7.
- Fixed mode: rr_en=0, out_ready=1, req=8'b0000_0011 -> next cycle out_valid=1, out_idx=1, out_onehot=8'b0000_0010. Then req=0 -> out_valid=0 after one handshake.
- Backpressure: hold out_ready=0 in HOLD with out_idx=1, change req to 8'b1000_0000 -> out_idx stays 1 for all stalled cycles. Then out_ready=1 -> next out_idx=7.
- Round-robin full load: rr_en=1, req=8'hFF held, out_ready=1 -> grant sequence 7,6,5,4,3,2,1,0,7 with one grant per cycle.
- Round-robin sparse: rr_en=1, req=8'b1000_0001 held -> grants alternate 7,0,7,0. Fixed mode with the same req -> 7,7,7.
- Reset mid-HOLD: rr_en=1, req=8'hFF, stop after the grant to 5 with out_ready=0, assert rst between edges -> out_valid falls without a clk edge. After release the first grant is 7, not 4.
